// File: rtl/branch_resolve_queue.sv
// rtl/branch_resolve_queue.sv - in-order predicted-direction queue with mispredict flush and history correction command
module branch_resolve_queue #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic       fire,
  input  logic       rst,
  input  logic       i_pushValid_1,
  input  logic       i_pushTaken_1,
  input  logic       i_resolveValid_1,
  input  logic       i_resolveTaken_1,
  output logic       o_full_1,
  output logic       o_empty_1,
  output logic [7:0] o_pendingB_8,
  output logic [2:0] o_passBNum_3,
  output logic       o_predictGotJ_1,
  output logic [7:0] o_newPendingB_8,
  output logic       o_mispredict_1,
  output logic       o_overflow_1,
  output logic       o_underflow_1
);

  typedef enum logic {RUN, FLUSH} state_t;

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  state_t           state;
  state_t           stateNext;
  logic             mem [DEPTH];
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W:0]   count;
  logic [PTR_W:0]   countNext;
  logic [PTR_W:0]   flushDepth;
  logic             fullReg;
  logic             emptyReg;
  logic             passOne;
  logic             predictReg;
  logic             overflowReg;
  logic             underflowReg;

  logic             acceptPush;
  logic             doPop;
  logic             doFlush;
  logic             setOvf;
  logic             setUnf;

  // Decide this cycle's queue action and next FSM state; FLUSH ignores all requests.
  always_comb begin
    stateNext  = state;
    acceptPush = 1'b0;
    doPop      = 1'b0;
    doFlush    = 1'b0;
    setOvf     = 1'b0;
    setUnf     = 1'b0;
    case (state)
      RUN: begin
        if (i_resolveValid_1) begin
          if (count == '0) begin
            setUnf = 1'b1;
          end else if (i_resolveTaken_1 == mem[rdPtr]) begin
            doPop = 1'b1;
          end else begin
            doFlush = 1'b1;
          end
        end
        if (doFlush) begin
          // A same-cycle push is younger than the mispredicted branch: drop it quietly.
          stateNext = FLUSH;
        end else if (i_pushValid_1) begin
          // A matching pop frees a slot on the same edge, so a full queue can still accept.
          if (count != DEPTH_C || doPop) begin
            acceptPush = 1'b1;
          end else begin
            setOvf = 1'b1;
          end
        end
      end
      FLUSH: begin
        stateNext = RUN;
      end
      default: begin
        stateNext = RUN;
      end
    endcase
  end

  // Occupancy after this edge; a flush empties the queue regardless of other traffic.
  always_comb begin
    countNext = count;
    if (doFlush) begin
      countNext = '0;
    end else begin
      countNext = count + (PTR_W+1)'(acceptPush) - (PTR_W+1)'(doPop);
    end
  end

  // FSM state register.
  always_ff @(posedge fire or posedge rst) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= stateNext;
    end
  end

  // Entry storage; contents beyond count are don't-care so no reset is needed.
  always_ff @(posedge fire) begin
    if (acceptPush) begin
      mem[wrPtr] <= i_pushTaken_1;
    end
  end

  // Pointers, occupancy and the depth captured at a mispredict.
  always_ff @(posedge fire or posedge rst) begin
    if (rst) begin
      rdPtr      <= '0;
      wrPtr      <= '0;
      count      <= '0;
      flushDepth <= '0;
      fullReg    <= 1'b0;
      emptyReg   <= 1'b1;
    end else begin
      count    <= countNext;
      fullReg  <= (countNext == DEPTH_C);
      emptyReg <= (countNext == '0);
      if (doFlush) begin
        rdPtr      <= wrPtr;
        flushDepth <= count;
      end else begin
        if (doPop) begin
          rdPtr <= rdPtr + PTR_W'(1);
        end
        if (acceptPush) begin
          wrPtr <= wrPtr + PTR_W'(1);
        end
      end
    end
  end

  // History shift command from the previous edge's accepted push, plus sticky error flags.
  always_ff @(posedge fire or posedge rst) begin
    if (rst) begin
      passOne      <= 1'b0;
      predictReg   <= 1'b0;
      overflowReg  <= 1'b0;
      underflowReg <= 1'b0;
    end else begin
      passOne    <= acceptPush;
      predictReg <= acceptPush & i_pushTaken_1;
      if (setOvf) begin
        overflowReg <= 1'b1;
      end
      if (setUnf) begin
        underflowReg <= 1'b1;
      end
    end
  end

  assign o_full_1        = fullReg;
  assign o_empty_1       = emptyReg;
  assign o_pendingB_8    = 8'(count);
  assign o_mispredict_1  = (state == FLUSH);
  assign o_passBNum_3    = (state == FLUSH) ? 3'b111 : {2'b00, passOne};
  assign o_predictGotJ_1 = predictReg;
  assign o_newPendingB_8 = (state == FLUSH) ? 8'(flushDepth) : 8'(count);
  assign o_overflow_1    = overflowReg;
  assign o_underflow_1   = underflowReg;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// tb/tb_branch_resolve_queue.sv - self-checking bench for branch_resolve_queue
module tb_branch_resolve_queue;

  localparam int DEPTH = 8;

  logic       fire;
  logic       rst;
  logic       pushValid;
  logic       pushTaken;
  logic       resolveValid;
  logic       resolveTaken;
  logic       full;
  logic       empty;
  logic [7:0] pendingB;
  logic [2:0] passBNum;
  logic       predictGotJ;
  logic [7:0] newPendingB;
  logic       mispredict;
  logic       overflow;
  logic       underflow;

  int nChecks = 0;
  int nFails  = 0;

  // Reference model: a plain queue of predicted directions plus flags.
  bit mq[$];
  bit mOvf;
  bit mUnf;
  bit mInFlush;
  int mFlushDepth;
  int mPass;
  bit mDir;

  typedef struct {
    bit pv;
    bit pt;
    bit rv;
    bit rt;
    int pend;
    int pass;
    bit dir;
    bit mis;
    int newPend;
    bit ovf;
    bit unf;
  } vec_t;

  vec_t vecs[$];

  branch_resolve_queue #(.DEPTH(8), .PTR_W(3)) dut (
    .fire             (fire),
    .rst              (rst),
    .i_pushValid_1    (pushValid),
    .i_pushTaken_1    (pushTaken),
    .i_resolveValid_1 (resolveValid),
    .i_resolveTaken_1 (resolveTaken),
    .o_full_1         (full),
    .o_empty_1        (empty),
    .o_pendingB_8     (pendingB),
    .o_passBNum_3     (passBNum),
    .o_predictGotJ_1  (predictGotJ),
    .o_newPendingB_8  (newPendingB),
    .o_mispredict_1   (mispredict),
    .o_overflow_1     (overflow),
    .o_underflow_1    (underflow)
  );

  initial fire = 1'b0;
  always #5 fire = ~fire;

  function automatic void chk(string name, int act, int exp);
    nChecks++;
    if (act != exp) begin
      nFails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic void modelReset();
    mq.delete();
    mOvf = 0;
    mUnf = 0;
    mInFlush = 0;
    mFlushDepth = 0;
    mPass = 0;
    mDir = 0;
  endfunction

  function automatic void modelEdge(bit pv, bit pt, bit rv, bit rt);
    bit popOk;
    bit mis;
    bit accept;
    if (mInFlush) begin
      mInFlush = 0;
      mPass = 0;
      mDir = 0;
      return;
    end
    popOk = 0;
    mis = 0;
    if (rv) begin
      if (mq.size() == 0) mUnf = 1;
      else if (mq[0] == rt) popOk = 1;
      else mis = 1;
    end
    if (mis) begin
      mFlushDepth = mq.size();
      mq.delete();
      mInFlush = 1;
      mPass = 0;
      mDir = 0;
    end else begin
      accept = pv && (mq.size() < DEPTH || popOk);
      if (pv && !accept) mOvf = 1;
      if (popOk) void'(mq.pop_front());
      if (accept) mq.push_back(pt);
      mPass = accept ? 1 : 0;
      mDir = accept & pt;
    end
  endfunction

  function automatic void checkModel(string tag);
    chk({tag, ".pend"}, int'(pendingB), mq.size());
    chk({tag, ".full"}, int'(full), (mq.size() == DEPTH) ? 1 : 0);
    chk({tag, ".empty"}, int'(empty), (mq.size() == 0) ? 1 : 0);
    chk({tag, ".pass"}, int'(passBNum), mInFlush ? 7 : mPass);
    chk({tag, ".dir"}, int'(predictGotJ), mInFlush ? 0 : int'(mDir));
    chk({tag, ".mis"}, int'(mispredict), int'(mInFlush));
    chk({tag, ".newPend"}, int'(newPendingB), mInFlush ? mFlushDepth : mq.size());
    chk({tag, ".ovf"}, int'(overflow), int'(mOvf));
    chk({tag, ".unf"}, int'(underflow), int'(mUnf));
  endfunction

  function automatic void checkReset(string tag);
    chk({tag, ".pend"}, int'(pendingB), 0);
    chk({tag, ".full"}, int'(full), 0);
    chk({tag, ".empty"}, int'(empty), 1);
    chk({tag, ".pass"}, int'(passBNum), 0);
    chk({tag, ".dir"}, int'(predictGotJ), 0);
    chk({tag, ".mis"}, int'(mispredict), 0);
    chk({tag, ".newPend"}, int'(newPendingB), 0);
    chk({tag, ".ovf"}, int'(overflow), 0);
    chk({tag, ".unf"}, int'(underflow), 0);
  endfunction

  task automatic step(input bit pv, input bit pt, input bit rv, input bit rt, input string tag);
    pushValid = pv;
    pushTaken = pt;
    resolveValid = rv;
    resolveTaken = rt;
    @(posedge fire);
    modelEdge(pv, pt, rv, rt);
    #1;
    checkModel(tag);
  endtask

  task automatic doReset(input string tag);
    rst = 1'b1;
    pushValid = 0;
    pushTaken = 0;
    resolveValid = 0;
    resolveTaken = 0;
    #1;
    checkReset(tag);
    @(posedge fire);
    #1;
    rst = 1'b0;
    modelReset();
  endtask

  function automatic void addVec(bit pv, bit pt, bit rv, bit rt, int pend, int pass,
                                 bit dir, bit mis, int newPend, bit ovf, bit unf);
    vecs.push_back('{pv, pt, rv, rt, pend, pass, dir, mis, newPend, ovf, unf});
  endfunction

  initial begin
    rst = 1'b1;
    pushValid = 0;
    pushTaken = 0;
    resolveValid = 0;
    resolveTaken = 0;
    modelReset();

    // Directed table: three pushes, mispredict with same-edge push, five pushes, mispredict, underflow.
    addVec(1, 1, 0, 0, 1, 1, 1, 0, 1, 0, 0);
    addVec(1, 0, 0, 0, 2, 1, 0, 0, 2, 0, 0);
    addVec(1, 1, 0, 0, 3, 1, 1, 0, 3, 0, 0);
    addVec(1, 1, 1, 0, 0, 7, 0, 1, 3, 0, 0);
    addVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 5; k++) addVec(1, 1, 0, 0, k, 1, 1, 0, k, 0, 0);
    addVec(0, 0, 1, 0, 0, 7, 0, 1, 5, 0, 0);
    addVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    addVec(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1);

    doReset("reset0");
    for (int i = 0; i < vecs.size(); i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      step(vecs[i].pv, vecs[i].pt, vecs[i].rv, vecs[i].rt, t);
      chk({t, ".tpend"}, int'(pendingB), vecs[i].pend);
      chk({t, ".tpass"}, int'(passBNum), vecs[i].pass);
      chk({t, ".tdir"}, int'(predictGotJ), int'(vecs[i].dir));
      chk({t, ".tmis"}, int'(mispredict), int'(vecs[i].mis));
      chk({t, ".tnew"}, int'(newPendingB), vecs[i].newPend);
      chk({t, ".tovf"}, int'(overflow), int'(vecs[i].ovf));
      chk({t, ".tunf"}, int'(underflow), int'(vecs[i].unf));
    end

    // Fill, overflow, then push+resolve while full.
    doReset("reset1");
    for (int i = 0; i < DEPTH; i++) step(1, 1'($urandom_range(0, 1)), 0, 0, "fill");
    chk("fill.full", int'(full), 1);
    step(1, 1, 0, 0, "over");
    chk("over.ovf", int'(overflow), 1);
    chk("over.pend", int'(pendingB), 8);
    chk("over.pass", int'(passBNum), 0);
    step(1, 0, 1, mq[0], "fullpair");
    chk("fullpair.pend", int'(pendingB), 8);
    chk("fullpair.pass", int'(passBNum), 1);
    chk("fullpair.mis", int'(mispredict), 0);

    // Underflow, then 20 matched push/resolve pairs to wrap the pointers.
    doReset("reset2");
    step(0, 0, 1, 1, "under");
    chk("under.unf", int'(underflow), 1);
    chk("under.pend", int'(pendingB), 0);
    step(1, 1, 0, 0, "prime");
    for (int i = 0; i < 20; i++) begin
      step(1, 1'($urandom_range(0, 1)), 1, mq[0], "wrap");
      chk("wrap.mis", int'(mispredict), 0);
      chk("wrap.pend", int'(pendingB), 1);
    end

    // Randomized traffic against the model, with occasional mispredicts.
    doReset("reset3");
    for (int i = 0; i < 400; i++) begin
      bit pv, pt, rv, rt;
      pv = 1'($urandom_range(0, 1));
      pt = 1'($urandom_range(0, 1));
      rv = ($urandom_range(0, 2) == 0);
      if (mq.size() > 0 && $urandom_range(0, 9) != 0) rt = mq[0];
      else rt = 1'($urandom_range(0, 1));
      step(pv, pt, rv, rt, "rand");
    end

    // Asynchronous reset in the middle of FLUSH.
    doReset("reset4");
    step(1, 1, 0, 0, "rf.p1");
    step(1, 1, 0, 0, "rf.p2");
    step(0, 0, 1, 0, "rf.mis");
    chk("rf.inflush", int'(mispredict), 1);
    #2;
    rst = 1'b1;
    #1;
    checkReset("rf.async");
    modelReset();
    @(posedge fire);
    #1;
    rst = 1'b0;
    step(0, 0, 0, 0, "rf.after");
    chk("rf.after.mis", int'(mispredict), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
